// File: rtl/pwm_adc_pkg.sv
// Shared types and defaults for the PWM-DAC based SAR ADC.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_adc_pkg;

  localparam int ADC_WIDTH   = 12;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DECIDE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer for a single asynchronous level, reset to 0.
// Latency: STAGES clocks from d to q.
// Backpressure: none (free-running).
// Ports: clk, reset_n (async active-low), d (async input), q (synchronized output).
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/pwm_sar_adc.sv
// SAR controller: drives PWM DAC trial codes, samples comparator after a settle window.
// Latency: WIDTH*(SETTLE_CYCLES+1)+1 clocks start->result_valid (x4 conversions with SAR_AVG4_EN).
// Backpressure: none; start is ignored while busy, result is a one-cycle strobe.
// Ports: clk, reset_n (async active-low), start, comp_in (async comparator),
//        duty_cycle (trial code to DAC), busy, result, result_valid.
// Option: define SAR_AVG4_EN to average 4 back-to-back conversions per start.
module pwm_sar_adc
  import pwm_adc_pkg::*;
#(
  parameter int WIDTH         = ADC_WIDTH,
  parameter int SETTLE_CYCLES = 20000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             comp_in,
  output logic [WIDTH-1:0] duty_cycle,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0]    SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [BW-1:0]    MSB_IDX     = BW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] trial_dec;
  logic [BW-1:0]    bit_idx;
  logic [CW-1:0]    settle_cnt;
  logic             comp_sync;
  logic [WIDTH-1:0] done_val;

  sync_2ff #(
    .STAGES (SYNC_STAGES)
  ) u_comp_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (comp_in),
    .q       (comp_sync)
  );

  // Trial code after the current bit's decision: drop the bit if the DAC overshot.
  always_comb begin
    trial_dec = trial;
    if (!comp_sync) begin
      trial_dec[bit_idx] = 1'b0;
    end
  end

`ifdef SAR_AVG4_EN
  logic [WIDTH+1:0] acc;
  logic [WIDTH+1:0] avg_sum;
  logic [1:0]       conv_cnt;

  assign avg_sum  = acc + {2'b00, trial};
  assign done_val = avg_sum[WIDTH+1:2];
`else
  assign done_val = trial;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      trial        <= '0;
      bit_idx      <= '0;
      settle_cnt   <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
`ifdef SAR_AVG4_EN
      acc          <= '0;
      conv_cnt     <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          // busy drops here, one cycle after the strobe, unless a new start is taken.
          busy <= start;
          if (start) begin
            trial      <= MSB_CODE;
            bit_idx    <= MSB_IDX;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
`ifdef SAR_AVG4_EN
            acc        <= '0;
            conv_cnt   <= '0;
`endif
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            state <= DECIDE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        DECIDE: begin
          if (bit_idx != '0) begin
            trial      <= trial_dec | (WIDTH'(1) << (bit_idx - BW'(1)));
            bit_idx    <= bit_idx - BW'(1);
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end else begin
`ifdef SAR_AVG4_EN
            if (conv_cnt != 2'd3) begin
              // Bank this conversion and restart at the MSB without an IDLE cycle.
              acc        <= acc + {2'b00, trial_dec};
              conv_cnt   <= conv_cnt + 2'd1;
              trial      <= MSB_CODE;
              bit_idx    <= MSB_IDX;
              settle_cnt <= SETTLE_LOAD;
              state      <= SETTLE;
            end else begin
              trial <= trial_dec;
              state <= DONE;
            end
`else
            trial <= trial_dec;
            state <= DONE;
`endif
          end
        end
        DONE: begin
          result       <= done_val;
          result_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The DAC always follows the trial register, so it holds the last code in IDLE.
  assign duty_cycle = trial;

endmodule

// File: tb/tb_pwm_sar_adc.sv
module tb_pwm_sar_adc;

  localparam int W = 12;
  localparam int S = 4;
  localparam int N = W * (S + 1);
`ifdef SAR_AVG4_EN
  localparam int LAT = 4 * N + 1;
`else
  localparam int LAT = N + 1;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         comp_in;
  logic [W-1:0] duty_cycle;
  logic         busy;
  logic [W-1:0] result;
  logic         result_valid;

  logic [W-1:0] vin_code = '0;
  int           comp_mode = 0;   // 0: model, 1: tied high, 2: tied low

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0;
  logic [W-1:0] exp_q[$];

  assign comp_in = (comp_mode == 1) ? 1'b1 :
                   (comp_mode == 2) ? 1'b0 : (vin_code > duty_cycle);

  pwm_sar_adc #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .comp_in      (comp_in),
    .duty_cycle   (duty_cycle),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every strobe must match the oldest expected result.
  always @(negedge clk) begin
    if (reset_n && result_valid) begin
      logic [W-1:0] e;
      n_valid++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: result=%0d, required no strobe", result);
      end else begin
        e = exp_q.pop_front();
        if (result !== e) begin
          errors++;
          $display("FAIL result: got %0d, required %0d", result, e);
        end
      end
    end
  end

  task automatic start_pulse(output int e0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b, required 1", busy);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int e0, input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        lat = cyc - e0;
        break;
      end
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic run_conv(input logic [W-1:0] vin, input int mode, input logic [W-1:0] expv);
    int e0, lat;
    comp_mode = mode;
    vin_code  = vin;
    exp_q.push_back(expv);
    start_pulse(e0);
    wait_valid(e0, LAT + 20, lat);
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL latency: got %0d, required %0d", lat, LAT);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_at_valid: got %b, required 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_done: busy=%b valid=%b, required 0 0", busy, result_valid);
    end
    checks++;
    if (duty_cycle !== expv || result !== expv) begin
      errors++;
      $display("FAIL hold_code: duty=%0d result=%0d, required %0d", duty_cycle, result, expv);
    end
  endtask

  task automatic test_reset();
    int bad;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (duty_cycle !== '0 || result !== '0 || busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: duty=%0d result=%0d busy=%b valid=%b, required all 0",
               duty_cycle, result, busy, result_valid);
    end
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || result_valid !== 1'b0 || duty_cycle !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d active cycles, required 0", bad);
    end
  endtask

  task automatic test_mid_scale();
    run_conv(12'd2731, 0, 12'hAAA);
  endtask

  task automatic test_full_scale();
    run_conv(12'd0, 1, 12'hFFF);
  endtask

  task automatic test_zero_scale();
    run_conv(12'd0, 2, 12'h000);
  endtask

  task automatic test_busy_protect();
    int e0, lat, nv0;
    comp_mode = 0;
    vin_code  = 12'd2731;
    exp_q.push_back(12'hAAA);
    nv0 = n_valid;
    start_pulse(e0);
    wait_until(e0 + 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(e0 + 30);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(e0, LAT + 20, lat);
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL busy_protect_latency: got %0d, required %0d", lat, LAT);
    end
    repeat (LAT + 20) @(negedge clk);
    checks++;
    if (n_valid - nv0 != 1) begin
      errors++;
      $display("FAIL busy_protect_count: got %0d strobes, required 1", n_valid - nv0);
    end
  endtask

  task automatic test_back_to_back();
    int e0, prev, lat, seen;
    comp_mode = 0;
    vin_code  = 12'd1000;
    repeat (3) exp_q.push_back(12'd999);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    prev = e0;
    seen = 0;
    for (int i = 0; i < 4 * (LAT + 1); i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        lat = cyc - prev;
        checks++;
        if (lat != ((seen == 0) ? LAT : LAT + 1)) begin
          errors++;
          $display("FAIL b2b_period: strobe %0d gap %0d, required %0d",
                   seen, lat, (seen == 0) ? LAT : LAT + 1);
        end
        prev = cyc;
        seen++;
        if (seen == 3) begin
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (seen != 3 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_end: strobes=%0d busy=%b pending=%0d, required 3 0 0",
               seen, busy, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_conv();
    int e0;
    run_conv(12'd0, 2, 12'h000);
    comp_mode = 0;
    vin_code  = 12'd2731;
    start_pulse(e0);
    wait_until(e0 + 27);
    reset_n = 1'b0;
    #1;
    checks++;
    if (duty_cycle !== '0 || busy !== 1'b0 || result !== '0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: duty=%0d busy=%b result=%0d valid=%b, required 0 0 0 0",
               duty_cycle, busy, result, result_valid);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_conv(12'd1000, 0, 12'd999);
  endtask

`ifdef SAR_AVG4_EN
  task automatic test_avg_step();
    int e0, lat;
    comp_mode = 0;
    vin_code  = 12'd1000;
    exp_q.push_back(12'd1005);
    start_pulse(e0);
    for (int k = 1; k <= 3; k++) begin
      wait_until(e0 + k * N);
      vin_code = 12'(1000 + 4 * k);
    end
    wait_valid(e0, LAT + 20, lat);
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL avg_latency: got %0d, required %0d", lat, LAT);
    end
    repeat (5) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_mid_scale();
    test_full_scale();
    test_zero_scale();
    test_busy_protect();
    test_back_to_back();
    test_reset_mid_conv();
`ifdef SAR_AVG4_EN
    test_avg_step();
`endif
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
